// File: rtl/catch_egg_game.sv
// catch_egg_game: catch-the-egg game with a row-scanned 8x4 LED matrix, driven straight from board pins.
module catch_egg_game #(
  parameter int FALL_DIV = 4096,
  parameter int SCAN_DIV = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic CLK,
  input  logic BTN_RST,
  input  logic BTN_1,
  input  logic BTN_2,
  output logic LED_R0,
  output logic LED_R1,
  output logic LED_R2,
  output logic LED_R3,
  output logic LED_R4,
  output logic LED_R5,
  output logic LED_R6,
  output logic LED_R7,
  output logic LED_C0,
  output logic LED_C1,
  output logic LED_C2,
  output logic LED_C3
);
  localparam int FW = FALL_DIV > 1 ? $clog2(FALL_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  typedef enum logic {PLAY, OVER} state_t;
  state_t state, state_n;
  logic [FW-1:0] fall_cnt;
  logic [SW-1:0] scan_cnt;
  logic [2:0] scan_row, egg_row, egg_row_n;
  logic [1:0] egg_col, egg_col_n, basket, basket_n, b1_s, b2_s;
  logic [7:0] lfsr, score, score_n, led_r;
  logic [3:0] led_c, led_c_n;
  logic pass, b1_prev, b2_prev;
  logic fall_wrap, scan_wrap, step, catch_egg, miss, fall1, fall2, mv_l, mv_r;
  assign fall_wrap = fall_cnt == FW'(FALL_DIV - 1);
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
  assign step = state == PLAY && fall_wrap;
  // the row-7 decision uses the basket as registered, before any same-cycle move
  assign catch_egg = step && egg_row == 3'd7 && egg_col == basket;
  assign miss = step && egg_row == 3'd7 && egg_col != basket;
  assign fall1 = b1_prev & ~b1_s[1];
  assign fall2 = b2_prev & ~b2_s[1];
  assign mv_l = state == PLAY && fall1 && !fall2 && basket != 2'd0;
  assign mv_r = state == PLAY && fall2 && !fall1 && basket != 2'd3;
  always_comb begin
    state_n = miss ? OVER : state;
    egg_row_n = !step ? egg_row : egg_row != 3'd7 ? egg_row + 3'd1 : catch_egg ? 3'd0 : egg_row;
    egg_col_n = catch_egg ? lfsr[1:0] : egg_col;
    score_n = catch_egg && score != 8'hFF ? score + 8'd1 : score;
    basket_n = mv_l ? basket - 2'd1 : mv_r ? basket + 2'd1 : basket;
    led_c_n = state == OVER ? {4{~pass}} :
              ((egg_row == scan_row) ? 4'b1 << egg_col : 4'b0) |
              ((scan_row == 3'd7) ? 4'b1 << basket : 4'b0);
  end
  always_ff @(posedge CLK) state <= BTN_RST ? PLAY : state_n;
  always_ff @(posedge CLK) begin
    if (BTN_RST) begin
      egg_row <= 3'd0;
      egg_col <= LFSR_SEED[1:0];
      basket <= 2'd1;
      score <= 8'd0;
      lfsr <= LFSR_SEED;
      fall_cnt <= '0;
      pass <= 1'b0;
      scan_cnt <= '0;
      scan_row <= 3'd0;
      b1_s <= 2'b11;
      b2_s <= 2'b11;
      b1_prev <= 1'b1;
      b2_prev <= 1'b1;
      led_r <= 8'd0;
      led_c <= 4'd0;
    end else begin
      egg_row <= egg_row_n;
      egg_col <= egg_col_n;
      basket <= basket_n;
      score <= score_n;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      fall_cnt <= fall_wrap ? '0 : fall_cnt + 1'b1;
      pass <= pass ^ fall_wrap;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      scan_row <= scan_row + {2'b0, scan_wrap};
      b1_s <= {b1_s[0], BTN_1};
      b2_s <= {b2_s[0], BTN_2};
      b1_prev <= b1_s[1];
      b2_prev <= b2_s[1];
      led_r <= 8'b1 << scan_row;
      led_c <= led_c_n;
    end
  end
  assign {LED_R7, LED_R6, LED_R5, LED_R4, LED_R3, LED_R2, LED_R1, LED_R0} = led_r;
  assign {LED_C3, LED_C2, LED_C1, LED_C0} = led_c;
endmodule

// File: tb/tb_catch_egg_game.sv
// tb_catch_egg_game: scoreboard bench comparing every LED frame with a time-based game model.
module tb_catch_egg_game;
  localparam int FD = 8;
  localparam int SD = 2;
  logic clk = 1'b0, rst = 1'b0, b1 = 1'b1, b2 = 1'b1;
  logic r0, r1, r2, r3, r4, r5, r6, r7, c0, c1, c2, c3;
  int checks = 0, fails = 0;
  logic [11:0] expq[$];
  logic [11:0] exp_v, act_v;
  int k, row, col, bas, score;
  bit over;
  logic [7:0] lf;
  logic [3:0] h1, h2;
  always #5 clk = ~clk;
  catch_egg_game #(.FALL_DIV(FD), .SCAN_DIV(SD), .LFSR_SEED(8'hA5)) dut (
    .CLK(clk), .BTN_RST(rst), .BTN_1(b1), .BTN_2(b2),
    .LED_R0(r0), .LED_R1(r1), .LED_R2(r2), .LED_R3(r3),
    .LED_R4(r4), .LED_R5(r5), .LED_R6(r6), .LED_R7(r7),
    .LED_C0(c0), .LED_C1(c1), .LED_C2(c2), .LED_C3(c3));
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  task automatic model_reset();
    k = 0; row = 0; col = 1; bas = 1; score = 0; over = 0;
    lf = 8'hA5; h1 = 4'hF; h2 = 4'hF;
  endtask
  task automatic tick(input logic r, input logic x1, input logic x2);
    logic [3:0] c;
    logic [7:0] rr;
    int srow;
    bit was_over, f1, f2;
    @(negedge clk);
    rst = r; b1 = x1; b2 = x2;
    if (r) begin
      expq.push_back(12'h000);
      model_reset();
    end else begin
      srow = (k / SD) % 8;
      rr = 8'h01 << srow;
      c = 4'h0;
      if (over) c = ((k / FD) % 2 == 0) ? 4'hF : 4'h0;
      else begin
        if (row == srow) c[col] = 1'b1;
        if (srow == 7) c[bas] = 1'b1;
      end
      expq.push_back({rr, c});
      h1 = {h1[2:0], x1};
      h2 = {h2[2:0], x2};
      f1 = h1[3] && !h1[2];
      f2 = h2[3] && !h2[2];
      was_over = over;
      if (!over && k % FD == FD - 1) begin
        if (row < 7) row++;
        else if (col == bas) begin
          score = score < 255 ? score + 1 : 255;
          row = 0;
          col = int'(lf & 8'h03);
        end else over = 1;
      end
      if (!was_over && f1 && !f2 && bas > 0) bas--;
      if (!was_over && f2 && !f1 && bas < 3) bas++;
      lf = lfsr_next(lf);
      k++;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b1, 1'b1);
  endtask
  task automatic press(input logic x1, input logic x2, input int n);
    repeat (n) tick(1'b0, x1, x2);
    idle(4);
  endtask
  always begin
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      act_v = {r7, r6, r5, r4, r3, r2, r1, r0, c3, c2, c1, c0};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL leds t=%0t rows/cols got %b_%b expected %b_%b", $time,
                 act_v[11:4], act_v[3:0], exp_v[11:4], exp_v[3:0]);
      end
    end
  end
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: test did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    model_reset();
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if ({r7, r6, r5, r4, r3, r2, r1, r0, c3, c2, c1, c0} !== 12'h000) begin
      fails++;
      $display("FAIL reset: LEDs not all 0 during reset");
    end
    idle(80);
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    press(1'b1, 1'b0, 4);
    idle(70);
    press(1'b0, 1'b1, 4);
    press(1'b1, 1'b0, 4);
    idle(40);
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    idle(36);
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    repeat (3) press(1'b0, 1'b1, 4);
    idle(16);
    repeat (5) press(1'b1, 1'b0, 4);
    idle(16);
    press(1'b0, 1'b0, 4);
    idle(16);
    press(1'b0, 1'b1, 100);
    idle(20);
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick(1'b1, 1'b1, 1'b1);
      repeat ($urandom_range(1, 40))
        tick(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected frames never compared", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/catch_egg_game.md
Name: catch_egg_game

Overview:
- Top-level "catch the egg" game for an 8-row x 4-column LED matrix.
- An egg falls from row 0 toward row 7. The player moves a one-pixel basket along row 7 with two active-low buttons.
- A catch scores a point and respawns the egg at a pseudo-random column. A miss ends the game until reset.
- The matrix is driven by row-multiplexed scanning; the block sits directly on board pins.

Parameters:
- FALL_DIV, 4096: clock cycles per egg step (one row).
- SCAN_DIV, 16: clock cycles per display row slot.
- LFSR_SEED, 8'hA5: non-zero reset value of the spawn LFSR.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- BTN_RST  in  1  synchronous, active-high reset.
- BTN_1  in  1  move-left button, active low (0 = pressed), asynchronous to CLK.
- BTN_2  in  1  move-right button, active low, asynchronous to CLK.
- LED_R0..LED_R7  out  1 each  row select, active high, one-hot while scanning.
- LED_C0..LED_C3  out  1 each  column data for the selected row, active high (1 = lit).

Behaviour:
- Reset (BTN_RST=1 at a clock edge) sets:
  - state=PLAY, egg_row=0, egg_col=LFSR_SEED[1:0] (=1 by default), basket_col=1, score=0.
  - lfsr=LFSR_SEED; all dividers and scan_row=0.
  - All LED_R* and LED_C* registered 0 during reset.
- Reset has priority over everything and may be asserted at any time, including in OVER.

Buttons:
- Each button passes through a 2-FF synchronizer, then press-edge detection (synced 1 -> 0).
- A press edge moves the basket one column on the following cycle: BTN_1 -> basket_col-1, BTN_2 -> basket_col+1.
- Moves clamp at 0 and 3; no wrap.
- Press edges on both buttons in the same cycle produce no move.
- Holding a button produces exactly one move.
- Moves are ignored in OVER.

LFSR:
- 8-bit Fibonacci LFSR with taps 8,6,5,4, advancing every clock in every state.
- Spawn column = lfsr[1:0] sampled at the respawn cycle.

Egg step:
- A free-running counter pulses a step once every FALL_DIV cycles, only in PLAY.
- On a step with egg_row<7: egg_row increments.
- On a step with egg_row==7, compare egg_col with basket_col as registered before any same-cycle move:
  - Equal (catch): score increments (8-bit, saturates at 255); egg_row=0; egg_col=lfsr[1:0].
  - Not equal (miss): state goes to OVER; egg position freezes.

States:
- PLAY -> OVER on a miss.
- OVER is left only by reset.

Display, PLAY:
- scan_row advances 0..7 and wraps, once every SCAN_DIV cycles.
- LED_R[scan_row]=1 and all other rows 0.
- LED_C[c]=1 when (egg_row==scan_row and egg_col==c) or (scan_row==7 and basket_col==c).
- The egg and basket may overlap at row 7.

Display, OVER:
- Scanning continues.
- All four LED_C are 1 during even-numbered passes of the egg-step counter and 0 during odd passes, i.e. a blink toggling every FALL_DIV cycles.

Outputs:
- All outputs are registered: one cycle latency from internal state.

Test Plan:
Plan parameters: FALL_DIV=8, SCAN_DIV=2.
- Reset: hold BTN_RST=1 for 2 cycles, then release -> all LEDs 0 during reset; afterwards LED_R0=1 with LED_C1=1 (egg at column 1), and row 7 slot shows LED_C1=1 (basket).
- Fall and catch, no buttons: after 7 steps (56 cycles) egg_row=7; the next step catches (basket_col 1 = egg_col 1) -> score=1, egg respawns at row 0 with column lfsr[1:0].
- Miss: press BTN_2 once (basket_col=2) before the egg reaches row 7 of an egg at column 1 -> next step at row 7 enters OVER; all four columns blink with period 2*FALL_DIV; further button presses are ignored.
- Clamp: press BTN_1 three times from basket_col=1 -> basket_col=0; press BTN_2 five times -> basket_col=3, never wrapping.
- Simultaneous/held: both buttons pressed on the same cycle -> basket unchanged; BTN_1 held low for 100 cycles -> exactly one move.
- Mid-game reset: assert BTN_RST while in OVER and while egg_row=4 -> both return to the reset state with score=0 and state=PLAY.
